// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } memState_t;

   localparam int defaultBaseAddr = 1024;

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Per-half-word wait counter: counts enabled cycles and flags the last one.
module sram_wait_counter #(
   parameter int SRAM_WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int CntW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

   logic [CntW-1:0] cnt;

   assign tc = (cnt == CntW'(SRAM_WAIT - 1));

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two half-word SRAM transfers,
// holding ready low (pipeline freeze) until the access completes.
module mem_stage_sram_ctrl
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter int BASE_ADDR = defaultBaseAddr,
   parameter int SRAM_WAIT = 2,
   parameter int ADDR_W    = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_val,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_we_n
);

   memState_t         state;
   logic [ADDR_W-2:0] wordQ;
   logic [31:0]       dataQ;
   logic              isWrite;
   logic              tc;
   logic              busy;
   logic              req;
   logic [31:0]       offset;
   logic [ADDR_W-2:0] reqWord;

   assign req     = mem_r_en | mem_w_en;
   assign busy    = (state == LO) || (state == HI);
   // Offset wraps silently; out-of-range addresses alias into the SRAM.
   assign offset  = alu_result - 32'(BASE_ADDR);
   assign reqWord = offset[ADDR_W:2];

   // IDLE term is combinational so a fresh request freezes the pipe at once.
   assign ready = (state == DONE) || ((state == IDLE) && !req);

   sram_wait_counter #(
      .SRAM_WAIT(SRAM_WAIT)
   ) u_waitCnt (
      .clk(clk),
      .rst(rst),
      .en (busy),
      .clr(!busy),
      .tc (tc)
   );

   // SRAM pins are registered and set up on the edge that enters each phase,
   // so reset drops the write strobe and bus drive without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wordQ       <= '0;
         dataQ       <= '0;
         isWrite     <= 1'b0;
         rdata       <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  wordQ       <= reqWord;
                  dataQ       <= store_val;
                  isWrite     <= mem_w_en;
                  state       <= LO;
                  sram_addr   <= {reqWord, 1'b0};
                  sram_dq_out <= mem_w_en ? store_val[15:0] : 16'h0000;
                  sram_dq_oe  <= mem_w_en;
                  sram_we_n   <= !mem_w_en;
               end
            end
            LO: begin
               if (tc) begin
                  if (!isWrite) rdata[15:0] <= sram_dq_in;
                  state       <= HI;
                  sram_addr   <= {wordQ, 1'b1};
                  sram_dq_out <= isWrite ? dataQ[31:16] : 16'h0000;
               end
            end
            HI: begin
               if (tc) begin
                  if (!isWrite) rdata[31:16] <= sram_dq_in;
                  state       <= DONE;
                  sram_addr   <= '0;
                  sram_dq_out <= '0;
                  sram_dq_oe  <= 1'b0;
                  sram_we_n   <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench: reset, write, read-back, back-to-back, abort, SRAM_WAIT=1.
module tb_mem_stage_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        mem_r_en, mem_w_en;
   logic [31:0] alu_result, store_val;
   logic        ready;
   logic [31:0] rdata;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        mem_r_en1, mem_w_en1;
   logic [31:0] alu_result1, store_val1;
   logic        ready1;
   logic [31:0] rdata1;
   logic [17:0] sram_addr1;
   logic [15:0] sram_dq_out1, sram_dq_in1;
   logic        sram_dq_oe1, sram_we_n1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_stage_sram_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_result(alu_result), .store_val(store_val),
      .ready(ready), .rdata(rdata),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   mem_stage_sram_ctrl #(.SRAM_WAIT(1)) dut1 (
      .clk(clk), .rst(rst),
      .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1),
      .alu_result(alu_result1), .store_val(store_val1),
      .ready(ready1), .rdata(rdata1),
      .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
      .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
   );

   // SRAM model: half-words 0 and 1 are preloaded constants, the rest writable.
   logic [15:0] mem [0:15];

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
   end

   assign sram_dq_in  = (sram_addr == 18'd0) ? 16'h1234 :
                        (sram_addr == 18'd1) ? 16'h5678 : mem[sram_addr[3:0]];
   assign sram_dq_in1 = 16'hAAAA;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic checkBus(input string tag, input logic rdyE, input logic [17:0] addrE,
                           input logic weE, input logic oeE, input logic [15:0] dqE);
      check({tag, ".ready"}, 32'(ready), 32'(rdyE));
      check({tag, ".addr"},  32'(sram_addr), 32'(addrE));
      check({tag, ".we_n"},  32'(sram_we_n), 32'(weE));
      check({tag, ".oe"},    32'(sram_dq_oe), 32'(oeE));
      check({tag, ".dq"},    32'(sram_dq_out), 32'(dqE));
   endtask

   // Caller drives the request 1 time unit after a rising edge (cycle 0).
   task automatic runAccess(input string tag, input logic isWr, input logic [17:0] a0,
                            input logic [15:0] lo, input logic [15:0] hi,
                            input logic [31:0] rdExp);
      #3;
      check({tag, ".c0.ready"}, 32'(ready), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #4;
         if (k <= 2)
            checkBus($sformatf("%s.c%0d", tag, k), 1'b0, a0, !isWr, isWr, isWr ? lo : 16'h0);
         else if (k <= 4)
            checkBus($sformatf("%s.c%0d", tag, k), 1'b0, a0 + 18'd1, !isWr, isWr, isWr ? hi : 16'h0);
         else begin
            checkBus($sformatf("%s.c%0d", tag, k), 1'b1, 18'd0, 1'b1, 1'b0, 16'h0);
            check({tag, ".rdata"}, rdata, rdExp);
         end
      end
   endtask

   initial begin
      mem_r_en  = 1'b0; mem_w_en  = 1'b0; alu_result  = '0; store_val  = '0;
      mem_r_en1 = 1'b0; mem_w_en1 = 1'b0; alu_result1 = '0; store_val1 = '0;

      // 1: reset, no request
      #24 rst = 1'b0;
      @(posedge clk); #4;
      checkBus("rst", 1'b1, 18'd0, 1'b1, 1'b0, 16'h0);
      check("rst.rdata", rdata, 32'h0);
      check("rst1.ready", 32'(ready1), 32'd1);
      check("rst1.we_n", 32'(sram_we_n1), 32'd1);

      // 2: write DEADBEEF at byte 1028 -> half-words 2 and 3
      @(posedge clk); #1;
      mem_w_en = 1'b1; alu_result = 32'd1028; store_val = 32'hDEADBEEF;
      runAccess("wr", 1'b1, 18'd2, 16'hBEEF, 16'hDEAD, 32'h0);

      // 3: read back the same word
      @(posedge clk); #1;
      mem_w_en = 1'b0; mem_r_en = 1'b1;
      runAccess("rd", 1'b0, 18'd2, 16'h0, 16'h0, 32'hDEADBEEF);

      // 4: read at 1024 held through DONE, then write at 1032 with no bubble
      @(posedge clk); #1;
      alu_result = 32'd1024;
      runAccess("b2b.rd", 1'b0, 18'd0, 16'h0, 16'h0, 32'h56781234);
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b1; alu_result = 32'd1032; store_val = 32'h0BADF00D;
      runAccess("b2b.wr", 1'b1, 18'd4, 16'hF00D, 16'h0BAD, 32'h56781234);

      // 5: reset asserted during the HI phase of a write
      @(posedge clk); #1;
      store_val = 32'h11112222;
      repeat (3) @(posedge clk);
      #2;
      check("abort.hi.we_n", 32'(sram_we_n), 32'd0);
      check("abort.hi.addr", 32'(sram_addr), 32'd5);
      rst = 1'b1;
      #1;
      checkBus("abort", 1'b0, 18'd0, 1'b1, 1'b0, 16'h0);
      check("abort.rdata", rdata, 32'h0);
      mem_w_en = 1'b0;
      #1;
      check("abort.idle.ready", 32'(ready), 32'd1);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #4;
      end
      checkBus("abort.noretry", 1'b1, 18'd0, 1'b1, 1'b0, 16'h0);

      // 6: SRAM_WAIT=1, both enables set -> write, ready in cycle 3
      @(posedge clk); #1;
      mem_r_en1 = 1'b1; mem_w_en1 = 1'b1; alu_result1 = 32'd1028; store_val1 = 32'hCAFEF00D;
      #3;
      check("w1.c0.ready", 32'(ready1), 32'd0);
      @(posedge clk); #4;
      check("w1.c1.addr", 32'(sram_addr1), 32'd2);
      check("w1.c1.we_n", 32'(sram_we_n1), 32'd0);
      check("w1.c1.oe", 32'(sram_dq_oe1), 32'd1);
      check("w1.c1.dq", 32'(sram_dq_out1), 32'h0000F00D);
      check("w1.c1.ready", 32'(ready1), 32'd0);
      @(posedge clk); #4;
      check("w1.c2.addr", 32'(sram_addr1), 32'd3);
      check("w1.c2.dq", 32'(sram_dq_out1), 32'h0000CAFE);
      check("w1.c2.ready", 32'(ready1), 32'd0);
      @(posedge clk); #4;
      check("w1.c3.ready", 32'(ready1), 32'd1);
      check("w1.c3.we_n", 32'(sram_we_n1), 32'd1);
      check("w1.c3.rdata", rdata1, 32'h0);
      @(posedge clk); #1;
      mem_r_en1 = 1'b0; mem_w_en1 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
